// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader for the single-cycle MIPS core.
// Takes a byte stream of {len_hi, len_lo, 4*len program bytes (big-endian
// words), xor checksum}, writes each word into instruction memory and holds
// the core in reset until the whole image has been received and verified.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   LEN_HI | waiting (without timeout) for the high byte of the word count
//   LEN_LO | waiting for the low byte; range-checks the full length
//   DATA   | assembling words MSB first, one imem write per 4 bytes
//   CSUM   | comparing the final byte with the running XOR
//   DONE   | image verified, core released; sticky until rst_n
//   ERR    | fault latched in err_code, core held; sticky until rst_n
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst_n,
  output logic              done,
  output logic [1:0]        err_code
);

  typedef enum logic [2:0] {
    LEN_HI = 3'd0,
    LEN_LO = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  // Idle timer counts down from TIMEOUT-1; it expires on the idle edge that
  // finds it at zero, which is the TIMEOUT-th idle cycle after a byte.
  localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT - 1);

  // Memory capacity in words, kept wide so the length compare cannot wrap.
  localparam logic [31:0] CAP_WORDS = 32'(1) << ADDR_W;

  state_t        state_q, state_d;
  logic [15:0]   len_q, len_d;
  logic [31:0]   asm_q, asm_d;
  logic [1:0]    byte_cnt_q, byte_cnt_d;
  logic [15:0]   word_cnt_q, word_cnt_d;
  logic [7:0]    xor_q, xor_d;
  logic [TW-1:0] idle_q, idle_d;

  logic              we_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic [1:0]        err_d;
  logic              rdy_d;
  logic              done_d;

  logic        accept;
  logic        busy;
  logic        timeout_hit;
  logic [31:0] asm_next;
  logic [15:0] len_full;

  assign accept      = rx_valid & rx_ready;
  assign busy        = (state_q == LEN_LO) || (state_q == DATA) || (state_q == CSUM);
  assign timeout_hit = busy && !accept && (idle_q == '0);
  assign asm_next    = {asm_q[23:0], rx_data};
  assign len_full    = {len_q[15:8], rx_data};

  // Next-state, datapath and next-output logic.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    asm_d      = asm_q;
    byte_cnt_d = byte_cnt_q;
    word_cnt_d = word_cnt_q;
    xor_d      = xor_q;
    idle_d     = idle_q;
    we_d       = 1'b0;
    addr_d     = imem_addr;
    wdata_d    = imem_wdata;
    err_d      = err_code;

    if (accept) begin
      idle_d = IDLE_LOAD;
    end

    case (state_q)
      LEN_HI: begin
        if (accept) begin
          len_d[15:8] = rx_data;
          xor_d       = rx_data;
          state_d     = LEN_LO;
        end
      end

      LEN_LO: begin
        if (accept) begin
          len_d[7:0] = rx_data;
          xor_d      = xor_q ^ rx_data;
          byte_cnt_d = 2'd0;
          word_cnt_d = 16'd0;
          if ({16'd0, len_full} > CAP_WORDS) begin
            state_d = ERR;
            err_d   = ERR_LEN;
          end else if (len_full == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end

      DATA: begin
        if (accept) begin
          asm_d      = asm_next;
          xor_d      = xor_q ^ rx_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            we_d       = 1'b1;
            addr_d     = ADDR_W'(word_cnt_q);
            wdata_d    = asm_next;
            word_cnt_d = word_cnt_q + 16'd1;
            if (word_cnt_q == (len_q - 16'd1)) begin
              state_d = CSUM;
            end
          end
        end
      end

      CSUM: begin
        if (accept) begin
          if (rx_data == xor_q) begin
            state_d = DONE;
          end else begin
            state_d = ERR;
            err_d   = ERR_CSUM;
          end
        end
      end

      default: begin
        // DONE and ERR are terminal until rst_n; bytes are refused.
      end
    endcase

    if (timeout_hit) begin
      state_d = ERR;
      err_d   = ERR_TIMEOUT;
    end else if (busy && !accept) begin
      idle_d = idle_q - TW'(1);
    end

    rdy_d  = (state_d == LEN_HI) || (state_d == LEN_LO) ||
             (state_d == DATA)   || (state_d == CSUM);
    done_d = (state_d == DONE);
  end

  // State register; rst_n aborts any load in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LEN_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q      <= '0;
      asm_q      <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      xor_q      <= '0;
      idle_q     <= '0;
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst_n <= 1'b0;
      done       <= 1'b0;
      err_code   <= '0;
    end else begin
      len_q      <= len_d;
      asm_q      <= asm_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
      xor_q      <= xor_d;
      idle_q     <= idle_d;
      rx_ready   <= rdy_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      core_rst_n <= done_d;
      done       <= done_d;
      err_code   <= err_d;
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of the instruction-memory loader with
// ADDR_W=8 and TIMEOUT=16. Outputs are sampled 1 time unit after the
// rising edge that produced them.
module tb_imem_loader;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 16;

  logic              clk;
  logic              rst_n;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst_n;
  logic              done;
  logic [1:0]        err_code;

  int n_assert = 0;
  int n_fail   = 0;
  int wr_total = 0;
  int base;

  imem_loader #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_rst_n(core_rst_n),
    .done      (done),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  // 10-unit clock.
  always #5 clk = ~clk;

  // Count memory write strobes, sampled mid-cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) wr_total++;
  end

  // Global runaway guard.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one byte for exactly one accepting edge; returns 1 unit after it.
  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Nominal stream 00 02 20 08 00 05 00 00 00 08 27 with cycle-exact checks.
  task automatic run_nominal(input string p);
    int b0;
    b0 = wr_total;
    send(8'h00); send(8'h02); send(8'h20); send(8'h08); send(8'h00);
    chk({p, "_pre_we"}, imem_we, 0);
    send(8'h05);
    chk({p, "_w0_we"}, imem_we, 1);
    chk({p, "_w0_addr"}, imem_addr, 0);
    chk({p, "_w0_data"}, imem_wdata, 32'h2008_0005);
    send(8'h00);
    chk({p, "_w0_we_one_cycle"}, imem_we, 0);
    send(8'h00); send(8'h00); send(8'h08);
    chk({p, "_w1_we"}, imem_we, 1);
    chk({p, "_w1_addr"}, imem_addr, 1);
    chk({p, "_w1_data"}, imem_wdata, 32'h0000_0008);
    chk({p, "_pre_done"}, done, 0);
    chk({p, "_pre_core_rst"}, core_rst_n, 0);
    send(8'h27);
    chk({p, "_done"}, done, 1);
    chk({p, "_core_rst"}, core_rst_n, 1);
    chk({p, "_err"}, err_code, 0);
    chk({p, "_rdy"}, rx_ready, 0);
    chk({p, "_wr_count"}, 32'(wr_total - b0), 2);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Reset values while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", rx_ready, 1);
    chk("rst_we", imem_we, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_core", core_rst_n, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_code, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: nominal load, then bytes offered in DONE are ignored.
    run_nominal("s1");
    base = wr_total;
    rx_data  = 8'hFF;
    rx_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    chk("s1_done_sticky", done, 1);
    chk("s1_done_ignore_we", 32'(wr_total - base), 0);
    chk("s1_done_ignore_addr", imem_addr, 1);
    chk("s1_done_ignore_err", err_code, 0);

    // 2: checksum fault.
    do_reset();
    base = wr_total;
    send(8'h00); send(8'h02); send(8'h20); send(8'h08); send(8'h00); send(8'h05);
    chk("s2_w0_data", imem_wdata, 32'h2008_0005);
    send(8'h00); send(8'h00); send(8'h00); send(8'h08);
    chk("s2_w1_data", imem_wdata, 32'h0000_0008);
    send(8'h26);
    chk("s2_err", err_code, 1);
    chk("s2_done", done, 0);
    chk("s2_core", core_rst_n, 0);
    chk("s2_rdy", rx_ready, 0);
    chk("s2_wr_count", 32'(wr_total - base), 2);
    repeat (20) @(posedge clk);
    #1;
    chk("s2_err_sticky", err_code, 1);
    chk("s2_core_held", core_rst_n, 0);

    // 3: empty image.
    do_reset();
    base = wr_total;
    send(8'h00); send(8'h00);
    chk("s3_done_early", done, 0);
    send(8'h00);
    chk("s3_done", done, 1);
    chk("s3_core", core_rst_n, 1);
    chk("s3_wr_count", 32'(wr_total - base), 0);

    // 4: length overflow (257 words), and the 256-word boundary is legal.
    do_reset();
    base = wr_total;
    send(8'h01);
    send(8'h01);
    chk("s4_err", err_code, 2);
    chk("s4_rdy", rx_ready, 0);
    chk("s4_core", core_rst_n, 0);
    chk("s4_wr_count", 32'(wr_total - base), 0);
    do_reset();
    send(8'h01);
    send(8'h00);
    chk("s4_cap_err", err_code, 0);
    chk("s4_cap_rdy", rx_ready, 1);

    // 5: timeout after 16 idle cycles, not before.
    do_reset();
    send(8'h00); send(8'h01); send(8'hAA);
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    chk("s5_err_not_yet", err_code, 0);
    chk("s5_rdy_not_yet", rx_ready, 1);
    @(posedge clk);
    #1;
    chk("s5_err", err_code, 3);
    chk("s5_rdy", rx_ready, 0);
    chk("s5_core", core_rst_n, 0);

    // 5b: LEN_HI never times out; a byte on the last idle edge still lands.
    do_reset();
    repeat (3 * TIMEOUT) @(posedge clk);
    #1;
    chk("s5b_lenhi_err", err_code, 0);
    chk("s5b_lenhi_rdy", rx_ready, 1);
    send(8'h00);
    repeat (TIMEOUT - 1) @(posedge clk);
    send(8'h00);
    chk("s5b_edge_err", err_code, 0);
    send(8'h00);
    chk("s5b_done", done, 1);
    chk("s5b_final_err", err_code, 0);

    // 6: reset pulse mid-load, then a clean nominal load.
    do_reset();
    send(8'h00); send(8'h02); send(8'h20); send(8'h08);
    rst_n = 1'b0;
    #1;
    chk("s6_pulse_core", core_rst_n, 0);
    chk("s6_pulse_rdy", rx_ready, 1);
    chk("s6_pulse_done", done, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("s6_after_core", core_rst_n, 0);
    run_nominal("s6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
